// File: rtl/ntr_cmd_sniffer_if.sv
// ntr_cmd_sniffer_if: NTR cartridge bus control lines (bus clock and chip select)
interface ntr_cmd_sniffer_if;
   logic ntr_clk;
   logic ntr_cs1;
   modport master (output ntr_clk, ntr_cs1);
   modport slave (input ntr_clk, ntr_cs1);
endinterface

// File: rtl/ntr_cmd_sniffer.sv
// ntr_cmd_sniffer: passive NTR command capture with LED status; NTR_DRIVE_EN enables data-phase pad driving
module ntr_tristate #(
   parameter int W = 8
) (
   input  logic         oe,
   input  logic [W-1:0] o,
   output logic [W-1:0] i,
   inout  wire  [W-1:0] pad
);
   assign pad = oe ? o : {W{1'bz}};
   assign i = pad;
endmodule

module ntr_cmd_sniffer #(
   parameter int         SYNC_STAGES = 2,
   parameter int         CMD_BYTES   = 8,
   parameter logic [7:0] MATCH_BYTE0 = 8'hFF
) (
   input  logic                clk,
   input  logic                rst_n,
   ntr_cmd_sniffer_if.slave    bus,
   inout  wire  [7:0]          ntr_data,
   output logic [3:0]          led
);
   localparam int CW = $clog2(CMD_BYTES + 1);
   localparam int IW = CMD_BYTES > 1 ? $clog2(CMD_BYTES) : 1;
   localparam logic [CW-1:0] FULL = CW'(CMD_BYTES);
   localparam logic [CW-1:0] LAST = CW'(CMD_BYTES - 1);

   logic [SYNC_STAGES-1:0] clk_sh, cs_sh;
   logic [7:0]             data_sh [SYNC_STAGES];
   logic                   clk_d, cs_d, armed, done_q;
   logic [CW-1:0]          cnt;
   logic [7:0]             cmd [CMD_BYTES];
   logic [7:0]             data_in, drive_val;
   logic                   drive_oe;

   wire       clk_s   = clk_sh[SYNC_STAGES-1];
   wire       cs_s    = cs_sh[SYNC_STAGES-1];
   wire [7:0] data_s  = data_sh[SYNC_STAGES-1];
   wire       rise    = clk_s & ~clk_d;
   wire       cs_rise = cs_s & ~cs_d;
   wire       cs_fall = ~cs_s & cs_d;
   // a new transaction restarts from byte 0 even if the previous end was missed
   wire [CW-1:0] cur = cs_fall ? '0 : cnt;
   wire       active  = rise & ~cs_s & armed;
   wire       cap     = active & (cur < FULL);

   ntr_tristate #(.W(8)) u_pad (.oe(drive_oe), .o(drive_val), .i(data_in), .pad(ntr_data));

   // synchronizers; data shares the clock depth so it lines up with the detected edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sh <= '0;
         cs_sh <= '0;
         for (int k = 0; k < SYNC_STAGES; k++) data_sh[k] <= '0;
         clk_d <= 1'b0;
         cs_d <= 1'b0;
      end else begin
         clk_sh <= {clk_sh[SYNC_STAGES-2:0], bus.ntr_clk};
         cs_sh <= {cs_sh[SYNC_STAGES-2:0], bus.ntr_cs1};
         data_sh[0] <= data_in;
         for (int k = 1; k < SYNC_STAGES; k++) data_sh[k] <= data_sh[k-1];
         clk_d <= clk_s;
         cs_d <= cs_s;
      end
   end

   // capture requires cs1 seen high since reset, so a reset mid-transaction waits for the next one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed <= 1'b0;
         cnt <= '0;
         done_q <= 1'b0;
         for (int k = 0; k < CMD_BYTES; k++) cmd[k] <= '0;
      end else begin
         if (cs_s) armed <= 1'b1;
         cnt <= cs_rise ? '0 : cap ? cur + 1'b1 : cs_fall ? '0 : cnt;
         if (cap) cmd[cur[IW-1:0]] <= data_s;
         done_q <= cap && cur == LAST;
      end
   end

   // status LEDs: completion updates bits 0,1,3 and clears 2; a short command sets bit 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led <= '0;
      else if (done_q) led <= {cmd[CMD_BYTES-1][0], 1'b0, cmd[0] == MATCH_BYTE0, ~led[0]};
      else if (cs_rise && cnt != '0 && cnt != FULL) led[2] <= 1'b1;
   end

`ifdef NTR_DRIVE_EN
   wire fall = ~clk_s & clk_d;
   logic [7:0] dcnt;
   logic       oe_q;
   assign drive_oe = oe_q;
   assign drive_val = dcnt;
   // data-phase clock counter driven onto the bus after each falling edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt <= '0;
         oe_q <= 1'b0;
      end else begin
         dcnt <= cs_s ? '0 : dcnt + {7'd0, active && cur == FULL};
         oe_q <= cs_s ? 1'b0 : (fall && armed && cur == FULL) ? 1'b1 : oe_q;
      end
   end
`else
   assign drive_oe = 1'b0;
   assign drive_val = '0;
`endif
endmodule

// File: tb/tb_ntr_cmd_sniffer.sv
// tb_ntr_cmd_sniffer: directed table-driven bench for ntr_cmd_sniffer
module tb_ntr_cmd_sniffer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tb_data = 8'h00;
   logic       tb_oe = 1'b1;
   logic [3:0] led;
   wire  [7:0] ntr_data;
   int         nvec = 0;
   int         nfail = 0;

   typedef struct {
      logic [63:0] cmd;
      int          nb;
      int          extra;
      logic [3:0]  exp;
   } vec_t;
   vec_t tbl [11];

   ntr_cmd_sniffer_if bus ();
   assign ntr_data = tb_oe ? tb_data : 8'bz;

   ntr_cmd_sniffer dut (.clk(clk), .rst_n(rst_n), .bus(bus), .ntr_data(ntr_data), .led(led));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: led=%b expected %b", name, act, exp);
      end
   endtask

   task automatic ntr_byte(input logic [7:0] b);
      tb_data = b;
      bus.ntr_clk = 1'b0;
      repeat (4) @(negedge clk);
      bus.ntr_clk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic run_cmd(input logic [63:0] c, input int nb, input int extra);
      bus.ntr_cs1 = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nb; i++) ntr_byte(c[63-8*i -: 8]);
      for (int i = 0; i < extra; i++) ntr_byte(8'h5A);
      bus.ntr_clk = 1'b0;
      repeat (4) @(negedge clk);
      bus.ntr_cs1 = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      tbl[0]  = '{64'hFF00_0000_0000_0000, 8, 1, 4'b0010};
      tbl[1]  = '{64'hAABB_CC00_0000_0000, 3, 0, 4'b0110};
      tbl[2]  = '{64'hFF00_0000_0000_0001, 8, 0, 4'b1011};
      tbl[3]  = '{64'h9F00_0000_0000_0001, 8, 0, 4'b1000};
      tbl[4]  = '{64'h1200_0000_0000_0000, 1, 0, 4'b1100};
      tbl[5]  = '{64'h0000_0000_0000_0000, 0, 0, 4'b1100};
      tbl[6]  = '{64'hFF00_0000_0000_0000, 8, 5, 4'b0011};
      tbl[7]  = '{64'hFF01_0203_0405_0600, 7, 0, 4'b0111};
      tbl[8]  = '{64'h9F00_0000_0000_0000, 8, 20, 4'b0000};
      tbl[9]  = '{64'hFF00_0000_0000_0001, 8, 0, 4'b1011};
      tbl[10] = '{64'h0000_0000_0000_0001, 8, 0, 4'b1000};
      bus.ntr_clk = 1'b0;
      bus.ntr_cs1 = 1'b1;
      // reset held with random bus activity
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.ntr_clk = 1'($urandom_range(0, 1));
         bus.ntr_cs1 = 1'($urandom_range(0, 1));
         tb_data = 8'($urandom);
         if (i % 5 == 4) begin
            check("reset_led", led, 4'b0000);
            check("reset_oe", {3'b000, dut.drive_oe}, 4'b0000);
         end
      end
      bus.ntr_clk = 1'b0;
      bus.ntr_cs1 = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("idle_after_reset", led, 4'b0000);
      // first command with exact latency check after the 8th rising edge
      bus.ntr_cs1 = 1'b0;
      repeat (4) @(negedge clk);
      ntr_byte(8'hFF);
      for (int i = 0; i < 6; i++) ntr_byte(8'h00);
      tb_data = 8'h01;
      bus.ntr_clk = 1'b0;
      repeat (4) @(negedge clk);
      bus.ntr_clk = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("latency", led, 4'b1011);
      repeat (3) @(negedge clk);
      bus.ntr_clk = 1'b0;
      repeat (4) @(negedge clk);
      bus.ntr_cs1 = 1'b1;
      repeat (8) @(negedge clk);
      check("end_full_cmd", led, 4'b1011);
      // table of transactions with cumulative LED expectations
      for (int v = 0; v < 11; v++) begin
         run_cmd(tbl[v].cmd, tbl[v].nb, tbl[v].extra);
         check($sformatf("vec%0d", v), led, tbl[v].exp);
      end
      // clocks while cs1 is high are ignored
      for (int i = 0; i < 10; i++) ntr_byte(8'h01);
      bus.ntr_clk = 1'b0;
      repeat (8) @(negedge clk);
      check("cs_high_clocks", led, 4'b1000);
      run_cmd(64'h9F00_0000_0000_0000, 8, 0);
      check("cmd_after_cs_high", led, 4'b0001);
      // cs1 rise together with the 8th edge: byte dropped, short command flagged
      bus.ntr_cs1 = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 7; i++) ntr_byte(8'hFF);
      tb_data = 8'h01;
      bus.ntr_clk = 1'b0;
      repeat (4) @(negedge clk);
      bus.ntr_clk = 1'b1;
      bus.ntr_cs1 = 1'b1;
      repeat (10) @(negedge clk);
      check("cs_rise_wins", led, 4'b0101);
      // reset mid-transaction, capture waits for cs1 high then low
      bus.ntr_clk = 1'b0;
      bus.ntr_cs1 = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++) ntr_byte(8'hFF);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_reset", led, 4'b0000);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) ntr_byte(8'hFF);
      ntr_byte(8'h01);
      bus.ntr_clk = 1'b0;
      repeat (4) @(negedge clk);
      bus.ntr_cs1 = 1'b1;
      repeat (8) @(negedge clk);
      check("unarmed_after_reset", led, 4'b0000);
      run_cmd(64'hFF00_0000_0000_0001, 8, 0);
      check("rearmed_cmd", led, 4'b1011);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/ntr_cmd_sniffer.md
Name: ntr_cmd_sniffer

Overview:
Passive monitor for an NTR (DS-style) cartridge bus: active-low chip select, bus clock and 8-bit bidirectional data.
- Samples bus signals into the system clock domain.
- Captures the 8-byte command that opens each transaction (ntr_cs1 low).
- Reports status on four LEDs.
- Sits at the board top level between the cartridge-slot pads and the LEDs.

Parameters:
SYNC_STAGES, 2, synchronizer depth for ntr_clk, ntr_cs1 and ntr_data (minimum 2).
CMD_BYTES, 8, command length in bytes.
MATCH_BYTE0, 8'hFF, value compared against command byte 0 to drive led[1].

Ports:
clk  input  1  system clock, at least 4x faster than ntr_clk.
rst_n  input  1  asynchronous active-low reset.
ntr_data  inout  8  cartridge data bus; tri-stated unless NTR_DRIVE_EN.
ntr_clk  input  1  cartridge bus clock; data valid at its rising edge.
ntr_cs1  input  1  chip select, active low.
led  output  4  status LEDs.

Behaviour:
- Interface: one clock; reset asynchronous, active-low.
- Reset values: led=4'b0000, byte counter=0, command buffer=0, ntr_data undriven (Z).
- Synchronization:
  - ntr_clk, ntr_cs1 and ntr_data each pass through SYNC_STAGES flops on clk.
  - Data uses the same depth as ntr_clk, so sampled data is aligned with the detected edge.
- Edge detect: one-cycle strobe when synchronized ntr_clk goes 0 to 1.
- Capture:
  - On each strobe with synchronized cs1 low and byte counter < CMD_BYTES, store the data byte at index = counter, then increment the counter.
  - Strobes with counter == CMD_BYTES are data-phase clocks: counted, data ignored, counter saturates.
  - Strobes while cs1 is high are ignored.
- Command complete: the cycle after byte CMD_BYTES-1 is stored:
  - led[0] toggles.
  - led[1] <= (byte0 == MATCH_BYTE0).
  - led[3] <= byte(CMD_BYTES-1) bit0.
  - led[2] <= 0.
  - Latency from the ntr_clk rising pad edge to the LED change: at most SYNC_STAGES+2 clk cycles.
- Transaction end (synchronized cs1 goes low to high):
  - Byte counter clears to 0.
  - If counter was between 1 and CMD_BYTES-1, led[2] <= 1 (short/aborted command); led[0], led[1] and led[3] are unchanged.
- Transaction start (cs1 high to low): counter forced to 0 even if the previous end was missed.
- Simultaneous cs1 rise and clock strobe in the same cycle: the cs1 rise wins; the byte is not stored.
- Reset mid-transaction: everything returns to reset values. Capture resumes only after cs1 is seen high, then low.
- Bidirectional pad: a generic tri-state wrapper (width parameter, output enable, pad, input, output) is instantiated for ntr_data. The input path is always the pad value.

Optional Feature:
Macro NTR_DRIVE_EN.
- Defined:
  - During the data phase (counter == CMD_BYTES, cs1 low), output enable asserts one clk after each synchronized ntr_clk falling edge.
  - The driven value is the 8-bit data-phase clock count.
  - Output enable deasserts on cs1 high or reset.
- Undefined: output enable is tied 0 and ntr_data is never driven.

Test Plan:
1. Reset: hold rst_n low with random bus activity -> led=0000 and ntr_data=Z throughout.
2. Command: cs1 low, 8 rising ntr_clk edges with data FF,00,00,00,00,00,00,01, then cs1 high -> led=1011 within SYNC_STAGES+2 clk of the 8th edge.
3. Second command: FF,00,00,00,00,00,00,00, then 1 extra clock -> led[0] toggles to 0, led[1]=1, led[3]=0; the extra clock changes nothing.
4. Abort: cs1 low, 3 bytes, cs1 high -> led[2]=1 and other bits unchanged; the next full command clears led[2].
5. Byte0 mismatch: command 9F,00,...,00 -> led[1]=0.
6. Clocks with cs1 high: 10 ntr_clk pulses, then a full command -> bytes captured from index 0 only.
